// File: rtl/dac_drs_ctrl.sv
// dac_drs_ctrl: slow-control front end for the DRS DAC serializer.
// Keeps shadow copies of the five DAC codes and drives stable active copies onto
// the serializer. Runs the dacset/finish/dac_en handshake with timeout detection,
// and provides registered read-back of all registers.
module dac_drs_ctrl #(
    parameter logic [15:0] ROFS_INIT = 16'h8000,
    parameter logic [15:0] OOFS_INIT = 16'h8000,
    parameter logic [15:0] BIAS_INIT = 16'h4000,
    parameter logic [15:0] CALP_INIT = 16'h8000,
    parameter logic [15:0] CALN_INIT = 16'h8000,
    parameter logic [15:0] TIMEOUT   = 16'd4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic [2:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic [15:0] DAC_ROFS,
    output logic [15:0] DAC_OOFS,
    output logic [15:0] DAC_BIAS,
    output logic [15:0] DAC_CALP,
    output logic [15:0] DAC_CALN,
    output logic        command_dacset,
    input  logic        command_dac_finish,
    input  logic        dac_en,
    output logic        busy,
    output logic        err,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_REQ  = 2'd2,
        S_DROP = 2'd3
    } state_t;

    localparam logic [15:0] TMO_LAST = TIMEOUT - 16'd1;

    state_t      r_state;
    logic [15:0] r_shadow [5];
    logic [15:0] r_active [5];
    logic        r_auto;
    logic        r_pending;
    logic        r_err;
    logic        r_done;
    logic        r_dacset;
    logic        r_timed_out;
    logic [15:0] r_tmo_cnt;
    logic [15:0] r_reload_cnt;
    logic [15:0] r_rd_data;

    logic        w_shadow_wr;
    logic        w_ctrl_wr;
    logic        w_pend_set;
    logic        w_err_clr;
    logic        w_busy;
    logic [15:0] w_rd_mux;

    assign w_shadow_wr = wr_en && (wr_addr <= 3'd4);
    assign w_ctrl_wr   = wr_en && (wr_addr == 3'd5);
    assign w_pend_set  = (w_ctrl_wr && wr_data[0]) || (w_shadow_wr && r_auto);
    assign w_err_clr   = w_ctrl_wr && wr_data[1];
    assign w_busy      = (r_state != S_IDLE);

    // Shadow registers and the stored auto bit; writes accepted in every state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow[0] <= ROFS_INIT;
            r_shadow[1] <= OOFS_INIT;
            r_shadow[2] <= BIAS_INIT;
            r_shadow[3] <= CALP_INIT;
            r_shadow[4] <= CALN_INIT;
            r_auto      <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 5; i++) begin
                if (w_shadow_wr && (wr_addr == 3'(i)))
                    r_shadow[i] <= wr_data;
            end
            if (w_ctrl_wr)
                r_auto <= wr_data[2];
        end
    end

    // Reload FSM with pending/err bookkeeping and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_active[0]  <= ROFS_INIT;
            r_active[1]  <= OOFS_INIT;
            r_active[2]  <= BIAS_INIT;
            r_active[3]  <= CALP_INIT;
            r_active[4]  <= CALN_INIT;
            r_pending    <= 1'b0;
            r_err        <= 1'b0;
            r_done       <= 1'b0;
            r_dacset     <= 1'b0;
            r_timed_out  <= 1'b0;
            r_tmo_cnt    <= '0;
            r_reload_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            // A timeout in the REQ branch below overrides this clear
            if (w_err_clr)
                r_err <= 1'b0;
            if (w_pend_set)
                r_pending <= 1'b1;
            case (r_state)
                // Transition uses the incoming set so an apply write reaches LOAD next cycle
                S_IDLE: begin
                    if ((r_pending || w_pend_set) && dac_en) begin
                        if (!w_pend_set)
                            r_pending <= 1'b0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_active    <= r_shadow;
                    if (!w_pend_set)
                        r_pending <= 1'b0;
                    r_tmo_cnt   <= '0;
                    r_timed_out <= 1'b0;
                    r_dacset    <= 1'b1;
                    r_state     <= S_REQ;
                end
                S_REQ: begin
                    if (command_dac_finish) begin
                        r_dacset <= 1'b0;
                        r_state  <= S_DROP;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_err       <= 1'b1;
                        r_timed_out <= 1'b1;
                        r_dacset    <= 1'b0;
                        r_state     <= S_DROP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
                end
                S_DROP: begin
                    if (dac_en) begin
                        if (!r_timed_out) begin
                            r_done       <= 1'b1;
                            r_reload_cnt <= r_reload_cnt + 16'd1;
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read-back multiplexer; status uses pre-edge values
    always_comb begin
        w_rd_mux = '0;
        case (rd_addr)
            3'd0:    w_rd_mux = r_shadow[0];
            3'd1:    w_rd_mux = r_shadow[1];
            3'd2:    w_rd_mux = r_shadow[2];
            3'd3:    w_rd_mux = r_shadow[3];
            3'd4:    w_rd_mux = r_shadow[4];
            3'd5:    w_rd_mux = {13'b0, r_auto, 2'b00};
            3'd6:    w_rd_mux = {12'b0, r_pending, w_busy, r_err, dac_en};
            3'd7:    w_rd_mux = r_reload_cnt;
            default: w_rd_mux = '0;
        endcase
    end

    // Registered read data, one cycle latency
    always_ff @(posedge clk) begin
        if (rst)
            r_rd_data <= '0;
        else
            r_rd_data <= w_rd_mux;
    end

    assign rd_data        = r_rd_data;
    assign DAC_ROFS       = r_active[0];
    assign DAC_OOFS       = r_active[1];
    assign DAC_BIAS       = r_active[2];
    assign DAC_CALP       = r_active[3];
    assign DAC_CALN       = r_active[4];
    assign command_dacset = r_dacset;
    assign busy           = w_busy;
    assign err            = r_err;
    assign done           = r_done;

endmodule
